// File: rtl/fetch_pc_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches words over req/ack and
// hands {pc, instr, pc+4} to the IF/ID register over valid/ready.
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_plus4,
    output logic        misalign
);

    typedef enum logic [1:0] {S_REQ, S_OUT, S_DROP} state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_pc, w_pc_nx;
    logic [31:0] r_pend, w_pend_nx;
    logic        r_valid, w_valid_nx;
    logic [31:0] r_opc, w_opc_nx;
    logic [31:0] r_instr, w_instr_nx;
    logic [31:0] r_opc4, w_opc4_nx;
    logic        r_misalign;

    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    assign w_target   = {redirect_pc[31:2], 2'b00};
    assign w_pc_plus4 = r_pc + 32'd4;

    // Request is gated by reset so it drops the instant reset asserts.
    assign imem_req     = rst_n && (r_state != S_OUT);
    assign imem_addr    = r_pc;
    assign out_valid    = r_valid;
    assign out_pc       = r_opc;
    assign out_instr    = r_instr;
    assign out_pc_plus4 = r_opc4;
    assign misalign     = r_misalign;

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_pend_nx  = r_pend;
        w_valid_nx = r_valid;
        w_opc_nx   = r_opc;
        w_instr_nx = r_instr;
        w_opc4_nx  = r_opc4;
        case (r_state)
            S_REQ: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        w_pc_nx = w_target;
                    end else begin
                        w_pend_nx  = w_target;
                        w_state_nx = S_DROP;
                    end
                end else if (imem_ack) begin
                    w_instr_nx = imem_rdata;
                    w_opc_nx   = r_pc;
                    w_opc4_nx  = w_pc_plus4;
                    w_valid_nx = 1'b1;
                    w_pc_nx    = w_pc_plus4;
                    w_state_nx = S_OUT;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    w_valid_nx = 1'b0;
                    w_pc_nx    = w_target;
                    w_state_nx = S_REQ;
                end else if (out_ready) begin
                    w_valid_nx = 1'b0;
                    w_state_nx = S_REQ;
                end
            end
            S_DROP: begin
                // Old request must complete at its original address; its data is dropped.
                if (redirect_valid) begin
                    if (imem_ack) begin
                        w_pc_nx    = w_target;
                        w_state_nx = S_REQ;
                    end else begin
                        w_pend_nx = w_target;
                    end
                end else if (imem_ack) begin
                    w_pc_nx    = r_pend;
                    w_state_nx = S_REQ;
                end
            end
            default: w_state_nx = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_pend     <= 32'd0;
            r_valid    <= 1'b0;
            r_opc      <= 32'd0;
            r_instr    <= 32'd0;
            r_opc4     <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_pc       <= w_pc_nx;
            r_pend     <= w_pend_nx;
            r_valid    <= w_valid_nx;
            r_opc      <= w_opc_nx;
            r_instr    <= w_instr_nx;
            r_opc4     <= w_opc4_nx;
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage: fetch, backpressure, squash, redirect, wrap, reset.
module tb_fetch_pc_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;
    logic        misalign;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    fetch_pc_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_pc_plus4(out_pc_plus4),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Memory model: each word's content is its address XOR KEY.
    always_comb imem_rdata = imem_addr ^ KEY;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_plus4", out_pc_plus4, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        #2 rst_n = 1'b1;
        #1;
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0);

        // Streaming fetch, ack and ready tied high
        imem_ack = 1'b1; out_ready = 1'b1;
        tick();
        chk("f0_valid", {31'd0, out_valid}, 32'd1);
        chk("f0_pc", out_pc, 32'h0);
        chk("f0_instr", out_instr, 32'hA5A5_A5A5);
        chk("f0_plus4", out_pc_plus4, 32'h4);
        chk("f0_req", {31'd0, imem_req}, 32'd0);
        chk("f0_addr", imem_addr, 32'h4);
        tick();
        chk("f0_drop_valid", {31'd0, out_valid}, 32'd0);
        chk("f1_req", {31'd0, imem_req}, 32'd1);
        chk("f1_addr", imem_addr, 32'h4);
        tick();
        chk("f1_pc", out_pc, 32'h4);
        chk("f1_instr", out_instr, 32'hA5A5_A5A1);
        tick();
        chk("f1_drop_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("f2_valid", {31'd0, out_valid}, 32'd1);
        chk("f2_pc", out_pc, 32'h8);
        chk("f2_instr", out_instr, 32'hA5A5_A5AD);

        // Backpressure: hold for 5 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_pc", out_pc, 32'h8);
            chk("bp_req", {31'd0, imem_req}, 32'd0);
            chk("bp_addr", imem_addr, 32'hC);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_rel_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_rel_req", {31'd0, imem_req}, 32'd1);
        chk("bp_rel_addr", imem_addr, 32'hC);

        // Wait states at 0xC with redirect to 0x100 in the first wait cycle
        imem_ack = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("drop_addr0", imem_addr, 32'hC);
        chk("drop_req0", {31'd0, imem_req}, 32'd1);
        tick();
        chk("drop_addr1", imem_addr, 32'hC);
        tick();
        chk("drop_addr2", imem_addr, 32'hC);
        imem_ack = 1'b1;
        tick();
        chk("drop_valid", {31'd0, out_valid}, 32'd0);
        chk("drop_next_addr", imem_addr, 32'h100);
        chk("drop_next_req", {31'd0, imem_req}, 32'd1);
        tick();
        chk("tgt_valid", {31'd0, out_valid}, 32'd1);
        chk("tgt_pc", out_pc, 32'h100);
        chk("tgt_instr", out_instr, 32'hA5A5_A4A5);
        out_ready = 1'b1;
        tick();
        chk("tgt_next_addr", imem_addr, 32'h104);

        // Redirect in S_OUT with out_ready high the same cycle
        tick();
        chk("so_valid", {31'd0, out_valid}, 32'd1);
        chk("so_pc", out_pc, 32'h104);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("so_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("so_flush_addr", imem_addr, 32'h40);
        chk("so_flush_req", {31'd0, imem_req}, 32'd1);
        tick();
        chk("so_tgt_pc", out_pc, 32'h40);
        chk("so_tgt_plus4", out_pc_plus4, 32'h44);
        tick();
        chk("so_next_addr", imem_addr, 32'h44);

        // Misaligned redirect while ack is high: data discarded, stays requesting
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_addr", imem_addr, 32'h200);
        chk("mis_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("mis_clear", {31'd0, misalign}, 32'd0);
        chk("mis_pc", out_pc, 32'h200);

        // Wraparound at top of address space
        tick();
        chk("wrap_pre_addr", imem_addr, 32'h204);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_nomis", {31'd0, misalign}, 32'd0);
        tick();
        chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", out_pc_plus4, 32'h0);
        chk("wrap_instr", out_instr, 32'h5A5A_5A59);
        chk("wrap_pc_next", imem_addr, 32'h0);
        tick();
        chk("wrap_next_addr", imem_addr, 32'h0);
        tick();
        tick();
        chk("pre_rst_addr", imem_addr, 32'h4);

        // Asynchronous reset asserted mid-S_REQ, off the clock edge
        imem_ack = 1'b0;
        tick();
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_pc", out_pc, 32'h0);
        tick();
        #2 rst_n = 1'b1;
        #1;
        chk("arel_addr", imem_addr, 32'h0);
        chk("arel_req", {31'd0, imem_req}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
